alu_functional_unit: RTL and testbench
======================================

# alu_functional_unit

Integer ALU functional unit that sits directly downstream of the reservation station. It accepts one ready instruction per cycle (operands already resolved) and computes the result in a registered execute stage. Results wait in an in-order result buffer until the common data bus (CDB) arbiter grants a broadcast slot. The broadcast tag/value pair is the RS/ROB wakeup source, and `fu_ready` back-pressures the RS issue signal.

## Interface
- `RESULT_DEPTH`, default 4: result buffer entries; power of two, ≥ 2.
- `PTR_WIDTH`, default 2: `$clog2(RESULT_DEPTH)`.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  RS issues an instruction this cycle.
- `func`  in  `ALU_FUNC`  operation.
- `v1`, `v2`  in  `XLEN` each  operands. Dispatch has already placed the immediate in `v2` where applicable.
- `dst_tag`  in  `ROB_TAG_LEN`  destination ROB tag.
- `fu_ready`  out  1  unit can accept `start` this cycle.
- `cdb_req`  out  1  result buffer head valid; requests the CDB.
- `cdb_grant`  in  1  arbiter grants the CDB this cycle.
- `cdb_tag`  out  `ROB_TAG_LEN`  head tag.
- `cdb_value`  out  `XLEN`  head result.
- `occupancy`  out  `PTR_WIDTH+1`  buffered results (debug/perf).

## Operation
- **Accept.** `start && fu_ready` at edge N latches `func`, `v1`, `v2`, `dst_tag` into stage E1 and sets `e1_valid`. `start` while `fu_ready=0` is ignored: nothing latches and no error is raised.
- **Execute.** `alu_core` evaluates the E1 contents combinationally. At edge N+1 the result and tag are written at the buffer tail, and `e1_valid` clears unless a new accept occurs in the same cycle.
- **Credit rule.** `fu_ready = !reset && (occupancy + e1_valid) < RESULT_DEPTH`.
  - Conservative: a same-cycle dequeue earns no credit.
  - Consequence: E1 never stalls and the buffer never overflows.
- **Broadcast.**
  - `cdb_req = (occupancy != 0)`.
  - `cdb_tag`/`cdb_value` come from the head entry, forced to 0 when the buffer is empty.
  - `cdb_req && cdb_grant` at an edge dequeues the head.
  - `cdb_grant` while `cdb_req=0` is ignored.
- **Ordering.** Strict FIFO; results broadcast in issue order.
- **Arithmetic.** All results are `XLEN` bits, modulo 2^XLEN.
  - ADD, SUB: two's-complement wrap.
  - AND, OR, XOR: bitwise.
  - SLT: signed compare; SLTU: unsigned compare; result is 0/1, zero-extended.
  - SLL, SRL: logical shifts by `v2[4:0]`; SRA: arithmetic shift by `v2[4:0]`.
  - Any other encoding produces 0.
- **Pointers.** Head and tail pointers are `PTR_WIDTH` bits and wrap naturally. `occupancy` is kept separately.
  - Enqueue + dequeue in the same cycle: occupancy unchanged, legal even when the buffer is full.
  - Enqueue only: +1. Dequeue only: −1.
- **Reset.** Clears `e1_valid`, pointers and `occupancy`. The instruction in E1 and all buffered results are discarded. This also applies to reset asserted mid-operation.

## Timing
- Output values while `reset` is high and on the first cycle after it:
  - `fu_ready`: 0 during reset, 1 on the first cycle after reset.
  - `cdb_req`: 0.
  - `cdb_tag`, `cdb_value`: 0.
  - `occupancy`: 0.
- Issue-to-request latency: `start` accepted at edge N → `cdb_req` high after edge N+1.
  - Minimum issue-to-broadcast: 2 edges.
  - Granted at edge N+2 → entry gone after N+2.
- Throughput: one accept and one broadcast per cycle in steady state with `cdb_grant` held high.
- `fu_ready` depends only on registered state and `reset`, with no combinational path from `start` or `cdb_grant`. The RS may therefore use it in the same cycle to gate `issue`.
- `cdb_tag`/`cdb_value` must be stable whenever `cdb_req` is high and no grant has occurred.

## Structure
- `ALU_FUNC`, `XLEN`, `ROB_TAG_LEN` come from `sys_defs.svh`.
- Add a `CDB_PACKET` struct {tag, value} to the shared header. The RS wakeup, ROB and arbiter all consume it.
- Sub-module `alu_core`: purely combinational (`func`, `a`, `b` → `result`), reused by later FUs.
- Result buffer is implemented inline; no generic FIFO module.

## Test plan
- Reset, then `start` ADD with `v1=1`, `v2=2`, `dst_tag=5`, `cdb_grant=1`:
  - `cdb_req` rises 1 cycle after accept, with `cdb_tag=5`, `cdb_value=3`.
  - `cdb_req` drops the next cycle.
- Operation coverage:
  - SUB 0x10−0x20 → 0xFFFFFFF0.
  - SLT(−1, 1) = 1; SLTU(0xFFFFFFFF, 1) = 0.
  - SRA(0x80000000, 4) = 0xF8000000; SLL with `v2=0x21` shifts by 1.
- Back-pressure: hold `cdb_grant=0` and issue every cycle.
  - `fu_ready` falls after the 4th accept; a 5th `start` is dropped.
  - `occupancy` reaches 4, `cdb_tag` stays at the first tag.
  - Releasing the grant broadcasts the 4 results in issue order.
- Full with simultaneous events: with `occupancy=3`, `e1_valid=1` and grant high, `occupancy` stays 3 for that edge and `fu_ready` stays 0.
- Pointer wrap: 10 back-to-back ops with grant toggling 1/0 → all tags are broadcast once, in order, with no loss across the wrap.
- Reset mid-operation: with 2 results buffered and E1 valid, assert `reset` for one cycle.
  - Next cycle: `cdb_req=0`, `occupancy=0`, `fu_ready=1`.
  - No stale tag is ever broadcast.

Source files
------------

// File: rtl/alu_functional_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_functional_unit_pkg
// Description : Shared ALU types: operand/tag widths, function codes and the
//               CDB broadcast packet consumed by RS wakeup, ROB and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_functional_unit_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } ALU_FUNC;

    typedef struct packed {
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
    } CDB_PACKET;

endpackage
`default_nettype wire

// File: rtl/alu_functional_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_functional_unit_if
// Description : Issue and CDB broadcast signals between RS/arbiter and the ALU
//               functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_functional_unit_if #(
    parameter int PTR_WIDTH = 2
);
    import alu_functional_unit_pkg::*;

    logic                   start;
    ALU_FUNC                func;
    logic [XLEN-1:0]        v1;
    logic [XLEN-1:0]        v2;
    logic [ROB_TAG_LEN-1:0] dst_tag;
    logic                   fu_ready;
    logic                   cdb_req;
    logic                   cdb_grant;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic [PTR_WIDTH:0]     occupancy;

    modport master (
        output start, func, v1, v2, dst_tag, cdb_grant,
        input  fu_ready, cdb_req, cdb_tag, cdb_value, occupancy
    );

    modport slave (
        input  start, func, v1, v2, dst_tag, cdb_grant,
        output fu_ready, cdb_req, cdb_tag, cdb_value, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/alu_functional_unit_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational integer ALU (func, a, b -> result),
//               shared by the integer functional units.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_functional_unit_pkg::*;
(
    input  ALU_FUNC         func,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] w_shamt;

    assign w_shamt = b[4:0];

    always_comb begin
        result = '0;
        case (func)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:  result = a << w_shamt;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $signed(a) >>> w_shamt;
            // Unassigned encodings deliberately yield zero
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_functional_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_functional_unit
// Description : Integer ALU FU: registered execute stage E1 feeding an in-order
//               result buffer that broadcasts on the CDB when granted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_functional_unit
    import alu_functional_unit_pkg::*;
#(
    parameter int RESULT_DEPTH = 4,
    parameter int PTR_WIDTH    = $clog2(RESULT_DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    alu_functional_unit_if.slave  fu
);

    localparam logic [PTR_WIDTH+1:0] c_result_depth = (PTR_WIDTH+2)'(RESULT_DEPTH);

    logic                   r_e1_valid;
    ALU_FUNC                r_e1_func;
    logic [XLEN-1:0]        r_e1_v1;
    logic [XLEN-1:0]        r_e1_v2;
    logic [ROB_TAG_LEN-1:0] r_e1_tag;

    CDB_PACKET              r_buf [RESULT_DEPTH];
    logic [PTR_WIDTH-1:0]   r_head;
    logic [PTR_WIDTH-1:0]   r_tail;
    logic [PTR_WIDTH:0]     r_occupancy;

    logic [XLEN-1:0]        w_e1_result;
    logic [PTR_WIDTH+1:0]   w_credit_used;
    logic                   w_fu_ready;
    logic                   w_accept;
    logic                   w_enq;
    logic                   w_deq;
    logic                   w_cdb_req;
    CDB_PACKET              w_head;

    // Credit counts the E1 slot too, so E1 always has a buffer entry to land in
    // and a same-cycle dequeue is never relied upon.
    assign w_credit_used = {1'b0, r_occupancy} + {{(PTR_WIDTH+1){1'b0}}, r_e1_valid};
    assign w_fu_ready    = !reset && (w_credit_used < c_result_depth);
    assign w_accept      = fu.start && w_fu_ready;
    assign w_enq         = r_e1_valid;
    assign w_cdb_req     = (r_occupancy != '0);
    assign w_deq         = w_cdb_req && fu.cdb_grant;
    assign w_head        = w_cdb_req ? r_buf[r_head] : '0;

    alu_core u_alu_core (
        .func   (r_e1_func),
        .a      (r_e1_v1),
        .b      (r_e1_v2),
        .result (w_e1_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e1_valid  <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
            r_occupancy <= '0;
        end else begin
            r_e1_valid <= w_accept;
            if (w_enq) begin
                r_tail <= r_tail + PTR_WIDTH'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_WIDTH'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_occupancy <= r_occupancy + (PTR_WIDTH+1)'(1);
                2'b01:   r_occupancy <= r_occupancy - (PTR_WIDTH+1)'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    // Payload registers need no reset: validity lives in r_e1_valid/r_occupancy
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_e1_func <= fu.func;
            r_e1_v1   <= fu.v1;
            r_e1_v2   <= fu.v2;
            r_e1_tag  <= fu.dst_tag;
        end
        if (w_enq) begin
            r_buf[r_tail] <= '{tag: r_e1_tag, value: w_e1_result};
        end
    end

    assign fu.fu_ready  = w_fu_ready;
    assign fu.cdb_req   = w_cdb_req;
    assign fu.cdb_tag   = w_head.tag;
    assign fu.cdb_value = w_head.value;
    assign fu.occupancy = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_alu_functional_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_functional_unit
// Description : Self-checking bench for alu_functional_unit with a queue-based
//               reference model and directed plus randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_functional_unit;
    import alu_functional_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic clk = 1'b0;
    logic reset;

    alu_functional_unit_if #(.PTR_WIDTH(PW)) bus ();

    alu_functional_unit #(
        .RESULT_DEPTH (DEPTH),
        .PTR_WIDTH    (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fu    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    CDB_PACKET                m_q[$];
    bit                       m_e1_v = 1'b0;
    CDB_PACKET                m_e1;
    bit                       m_acc;
    logic [ROB_TAG_LEN-1:0]   dut_log[$];

    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh   = b[4:0];
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (f)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + (~b + 32'd1);
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return (a >> sh) | fill;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        bit exp_ready;
        exp_ready = !reset && ((m_q.size() + int'(m_e1_v)) < DEPTH);
        check("fu_ready",  64'(bus.fu_ready),  64'(exp_ready));
        check("cdb_req",   64'(bus.cdb_req),   64'(m_q.size() != 0));
        check("cdb_tag",   64'(bus.cdb_tag),   (m_q.size() != 0) ? 64'(m_q[0].tag)   : 64'h0);
        check("cdb_value", 64'(bus.cdb_value), (m_q.size() != 0) ? 64'(m_q[0].value) : 64'h0);
        check("occupancy", 64'(bus.occupancy), 64'(m_q.size()));
    endtask

    // One clock: predict from pre-edge inputs, advance the model, then compare.
    task automatic tick();
        bit        rdy;
        bit        deq;
        CDB_PACKET pkt;
        rdy = !reset && ((m_q.size() + int'(m_e1_v)) < DEPTH);
        deq = (m_q.size() != 0) && bus.cdb_grant;
        m_acc = bus.start && rdy;
        pkt = '{tag: bus.dst_tag, value: alu_ref(bus.func, bus.v1, bus.v2)};
        if (bus.cdb_req && bus.cdb_grant && !reset) dut_log.push_back(bus.cdb_tag);
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_e1_v = 1'b0;
        end else begin
            if (deq) void'(m_q.pop_front());
            if (m_e1_v) m_q.push_back(m_e1);
            m_e1_v = m_acc;
            if (m_acc) m_e1 = pkt;
        end
        #1;
        compare_outputs();
    endtask

    task automatic issue(input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.start   = 1'b1;
        bus.func    = f;
        bus.v1      = a;
        bus.v2      = b;
        bus.dst_tag = tag;
    endtask

    task automatic op_check(input string tag, input ALU_FUNC f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        bus.cdb_grant = 1'b1;
        issue(f, a, b, 5'd7);
        tick();
        bus.start = 1'b0;
        tick();
        check(tag, 64'(bus.cdb_value), 64'(exp));
        tick();
    endtask

    initial begin
        int issued;
        int cyc;
        logic [4:0] exp_tags [3];

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.func      = ALU_ADD;
        bus.v1        = '0;
        bus.v2        = '0;
        bus.dst_tag   = '0;
        bus.cdb_grant = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready", 64'(bus.fu_ready), 64'h0);
        check("rst_req",   64'(bus.cdb_req),  64'h0);
        check("rst_occ",   64'(bus.occupancy), 64'h0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.fu_ready), 64'h1);
        compare_outputs();

        // First ADD: request one cycle after accept, gone the cycle after
        bus.cdb_grant = 1'b1;
        issue(ALU_ADD, 32'd1, 32'd2, 5'd5);
        tick();
        bus.start = 1'b0;
        tick();
        check("add_req",   64'(bus.cdb_req),   64'h1);
        check("add_tag",   64'(bus.cdb_tag),   64'h5);
        check("add_value", 64'(bus.cdb_value), 64'h3);
        tick();
        check("add_req_drop", 64'(bus.cdb_req), 64'h0);

        // Operation coverage
        op_check("sub",  ALU_SUB,  32'h10,        32'h20, 32'hFFFF_FFF0);
        op_check("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'h1,  32'h1);
        op_check("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1,  32'h0);
        op_check("sra",  ALU_SRA,  32'h8000_0000, 32'h4,  32'hF800_0000);
        op_check("sll",  ALU_SLL,  32'h3,         32'h21, 32'h6);
        op_check("bad",  ALU_FUNC'(4'hF), 32'h1234, 32'h5678, 32'h0);

        // Back-pressure with grant held low
        bus.cdb_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(ALU_ADD, 32'(i), 32'd100, 5'(10 + i));
            tick();
            if (i == 3) check("bp_ready_low", 64'(bus.fu_ready), 64'h0);
        end
        bus.start = 1'b0;
        tick();
        check("bp_occ_full", 64'(bus.occupancy), 64'h4);
        check("bp_head_tag", 64'(bus.cdb_tag),   64'd10);
        bus.cdb_grant = 1'b1;
        exp_tags[0] = 5'd11;
        exp_tags[1] = 5'd12;
        exp_tags[2] = 5'd13;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_order", 64'(bus.cdb_tag), 64'(exp_tags[i]));
        end
        tick();
        check("bp_empty", 64'(bus.cdb_req), 64'h0);

        // Full buffer + E1 valid + grant: no same-cycle credit
        bus.cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(ALU_XOR, $urandom, $urandom, 5'(1 + i));
            tick();
        end
        issue(ALU_OR, 32'h1, 32'h2, 5'd9);
        bus.cdb_grant = 1'b1;
        #1;
        check("full_ready_low", 64'(bus.fu_ready),  64'h0);
        check("full_occ_pre",   64'(bus.occupancy), 64'h3);
        tick();
        check("full_occ_hold",  64'(bus.occupancy), 64'h3);
        bus.start = 1'b0;
        repeat (5) tick();

        // Pointer wrap: 10 back-to-back ops, grant toggling
        dut_log.delete();
        issued = 0;
        cyc    = 0;
        while ((issued < 10 || m_q.size() != 0 || m_e1_v) && cyc < 80) begin
            bus.cdb_grant = (cyc % 2 == 0);
            if (issued < 10) issue(ALU_FUNC'($urandom_range(0, 15)), $urandom, $urandom, 5'(20 + issued));
            else bus.start = 1'b0;
            tick();
            if (m_acc) issued++;
            cyc++;
        end
        bus.start = 1'b0;
        check("wrap_drained", 64'(issued + m_q.size() + int'(m_e1_v)), 64'd10);
        check("wrap_count", 64'(dut_log.size()), 64'd10);
        for (int i = 0; i < dut_log.size() && i < 10; i++)
            check("wrap_order", 64'(dut_log[i]), 64'(20 + i));

        // Reset mid-operation: two buffered, one in E1
        bus.cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(ALU_ADD, 32'(i), 32'd1, 5'(1 + i));
            tick();
        end
        bus.start = 1'b0;
        check("mid_occ_pre", 64'(bus.occupancy), 64'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_req",   64'(bus.cdb_req),   64'h0);
        check("mid_occ",   64'(bus.occupancy), 64'h0);
        check("mid_ready", 64'(bus.fu_ready),  64'h1);
        dut_log.delete();
        bus.cdb_grant = 1'b1;
        repeat (4) tick();
        check("mid_no_stale", 64'(dut_log.size()), 64'h0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            issue(ALU_FUNC'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                  5'($urandom_range(0, 31)));
            bus.start     = ($urandom_range(0, 3) != 0);
            bus.cdb_grant = ($urandom_range(0, 4) < 3);
            reset         = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.cdb_grant = 1'b1;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
